instr_feeder: RTL



---
 rtl/scu_pkg.sv | 15 +
 rtl/instr_feeder_if.sv | 30 +++
 rtl/instr_feeder_rom.sv | 30 +++
 rtl/instr_feeder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/scu_pkg.sv
// Shared definitions for the simple control-unit processor and its instruction feeder.
package scu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned OP_MSB = 8;

    localparam logic [OP_W-1:0] OP_MV   = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

endpackage

// File: rtl/instr_feeder_if.sv
// Control, program-load and processor-facing signals of the instruction feeder.
interface instr_feeder_if
    import scu_pkg::*;
#(
    parameter int unsigned AW = 5
);
    logic              Start;
    logic              Done;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [WORD_W-1:0] prog_wdata;
    logic [WORD_W-1:0] Din;
    logic              Run;
    logic              Busy;
    logic              Halted;
    logic              Error;
    logic [AW-1:0]     pc;

    // Environment side: drives control and program load, observes the feeder.
    modport master (
        output Start, Done, prog_we, prog_addr, prog_wdata,
        input  Din, Run, Busy, Halted, Error, pc
    );

    // Feeder side.
    modport slave (
        input  Start, Done, prog_we, prog_addr, prog_wdata,
        output Din, Run, Busy, Halted, Error, pc
    );
endinterface

// File: rtl/instr_feeder_rom.sv
// Program memory: synchronous write, two asynchronous read ports, contents not reset.
module feeder_rom
    import scu_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [WORD_W-1:0] rdata_a_c,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [WORD_W-1:0] rdata_b_c
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_c = mem_q[raddr_a_i];
    assign rdata_b_c = mem_q[raddr_b_i];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: steps through program memory, issuing words on Din with a Run
// strobe and waiting for Done, with end-of-program and timeout detection.
// Optional build macro INSTR_FEEDER_LOOP_EN: pc wraps and the program repeats.
module instr_feeder
    import scu_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           Reset,
    instr_feeder_if.slave  bus
);

`ifdef INSTR_FEEDER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_IMM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic              is_mvi_q, is_mvi_d;

    logic              start_ok;
    logic              adv;
    logic              end_hit;
    logic              enter_issue;
    logic [AW:0]       npc;
    logic [AW-1:0]     raddr_b;
    logic [WORD_W-1:0] rd_a;
    logic [WORD_W-1:0] rd_b;
    logic [OP_W-1:0]   op_a;
    logic              mvi_end;
    logic              prog_we_ok;

    // Program writes are only accepted while the sequencer is not running.
    assign prog_we_ok = bus.prog_we && !busy_q;
    // Port A reads the instruction at the next pc; port B reads the immediate slot.
    assign raddr_b    = pc_q + AW'(1);

    feeder_rom #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .clk       (clk),
        .we_i      (prog_we_ok),
        .waddr_i   (bus.prog_addr),
        .wdata_i   (bus.prog_wdata),
        .raddr_a_i (pc_d),
        .rdata_a_c (rd_a),
        .raddr_b_i (raddr_b),
        .rdata_b_c (rd_b)
    );

    assign op_a    = rd_a[OP_MSB:OP_LSB];
    assign mvi_end = (op_a == OP_MVI) && (pc_d == AW'(DEPTH - 1)) && !LOOP_EN;

    // Next-pc datapath: restart at 0 on Start, advance by instruction length on Done.
    always_comb begin
        start_ok    = bus.Start && ((state_q == S_IDLE) || (state_q == S_HALT));
        adv         = (state_q == S_WAIT) && bus.Done;
        npc         = {1'b0, pc_q} + (AW+1)'(is_mvi_q ? 2'd2 : 2'd1);
        end_hit     = npc[AW] && !LOOP_EN;
        enter_issue = start_ok || (adv && !end_hit);
        pc_d        = pc_q;
        if (start_ok) begin
            pc_d = '0;
        end else if (adv && !end_hit) begin
            pc_d = npc[AW-1:0];
        end
    end

    // Next-state and registered-output logic; issue outputs are looked ahead from mem[pc_d].
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        run_d    = 1'b0;
        halted_d = halted_q;
        error_d  = error_q;
        is_mvi_d = is_mvi_q;

        case (state_q)
            S_IDLE: begin
                din_d = '0;
                if (start_ok) begin
                    state_d  = S_ISSUE;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (op_a == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    din_d    = '0;
                end else if (mvi_end) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    error_d  = 1'b1;
                    din_d    = '0;
                end else if (op_a == OP_MVI) begin
                    state_d = S_IMM;
                    din_d   = rd_b;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_IMM: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (bus.Done) begin
                    if (end_hit) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        din_d    = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    error_d  = 1'b1;
                    din_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HALT: begin
                din_d = '0;
                if (start_ok) begin
                    state_d  = S_ISSUE;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                din_d   = '0;
            end
        endcase

        if (enter_issue) begin
            is_mvi_d = (op_a == OP_MVI);
            if ((op_a == OP_HALT) || mvi_end) begin
                run_d = 1'b0;
                din_d = '0;
            end else begin
                run_d = 1'b1;
                din_d = rd_a;
            end
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            is_mvi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            is_mvi_q <= is_mvi_d;
        end
    end

    assign bus.Din    = din_q;
    assign bus.Run    = run_q;
    assign bus.Busy   = busy_q;
    assign bus.Halted = halted_q;
    assign bus.Error  = error_q;
    assign bus.pc     = pc_q;

endmodule
